// File: rtl/op_sram_reader.sv
// op_sram_reader: reads a contiguous range of OP SRAM words and streams them out over valid/ready.
// Define OP_READ_CHECKSUM_EN to add a running XOR checksum of the accepted words.
module op_sram_reader #(
  parameter int unsigned ADDR_BW   = 9,
  parameter int unsigned DATA_BW   = 128,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_BW-1:0] base_addr,
  input  logic [ADDR_BW:0]   num_words,
  output logic               busy,
  output logic               done,
  input  logic [DATA_BW-1:0] OP_q,
  output logic [ADDR_BW-1:0] OP_addr,
  output logic               OP_cen,
  output logic               OP_wen,
  output logic [DATA_BW-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready
`ifdef OP_READ_CHECKSUM_EN
  ,
  output logic [DATA_BW-1:0] checksum
`endif
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} state_e;

  localparam logic [ADDR_BW:0] CntOne = {{ADDR_BW{1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [ADDR_BW-1:0] base_q;
  logic [ADDR_BW:0]   num_q;
  logic [ADDR_BW:0]   issued_q, issued_d;
  logic [ADDR_BW:0]   accepted_q, accepted_d;
  logic               inflight_q;
  logic [DATA_BW-1:0] buf_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q, count_d, count_after_pop;
  logic               issue, push, pop, room, launch;

  assign push      = inflight_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = buf_q[rd_ptr_q];
  assign pop       = out_valid && out_ready;
  assign launch    = (state_q == StIdle) && start;

  // A read may only be issued if its word is guaranteed a free slot when it lands.
  assign count_after_pop = count_q - {1'b0, pop};
  assign room = (32'(count_after_pop) + 32'(inflight_q)) < BUF_DEPTH;

  assign OP_cen = ~issue;
  assign OP_wen = 1'b1;
  assign busy   = (state_q == StRead) || (state_q == StDrain);
  assign done   = (state_q == StFin);

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    OP_addr    = '0;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    if (pop) begin
      accepted_d = accepted_q + CntOne;
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          issued_d   = '0;
          accepted_d = '0;
          if (num_words == '0) begin
            state_d = StFin;
          end else begin
            // First read goes out in the start cycle to keep start->first word at 2 cycles.
            issue    = 1'b1;
            OP_addr  = base_addr;
            issued_d = CntOne;
            state_d  = (num_words == CntOne) ? StDrain : StRead;
          end
        end
      end
      StRead: begin
        if ((issued_q != num_q) && room) begin
          issue    = 1'b1;
          OP_addr  = base_q + issued_q[ADDR_BW-1:0];
          issued_d = issued_q + CntOne;
          if ((issued_q + CntOne) == num_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if ((accepted_q == num_q) && (count_q == 2'd0)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      inflight_q <= issue;
      if (launch) begin
        base_q <= base_addr;
        num_q  <= num_words;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= OP_q;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

`ifdef OP_READ_CHECKSUM_EN
  logic [DATA_BW-1:0] checksum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_q <= '0;
    end else if (launch) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q ^ out_data;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: doc/op_sram_reader.md
Name: op_sram_reader

Overview:
- Read-side engine for the output/psum SRAM (128-bit data, 9-bit address, active-low CEN/WEN).
- Once the corelet finishes compute, it reads a contiguous range of OP words and streams them to the host side over a valid/ready interface.
- It is the consumer-side counterpart of the corelet's OP write path. It drives the same OP SRAM pins through the core's SRAM select mux.
- A 2-entry output buffer absorbs the SRAM's 1-cycle read latency, so back-pressure never drops or duplicates a word.

Parameters:
- ADDR_BW, 9, OP SRAM address width.
- DATA_BW, 128, OP SRAM word width (8 columns x 16-bit psum).
- BUF_DEPTH, 2, output buffer entries. Fixed at 2; any other value is unsupported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle pulse; launches a transfer. Ignored while busy=1.
- base_addr  in  ADDR_BW  first OP address; sampled on start.
- num_words  in  ADDR_BW+1  word count; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last word is accepted downstream.
- OP_q  in  DATA_BW  SRAM read data, valid the cycle after a read (CEN=0, WEN=1).
- OP_addr  out  ADDR_BW  SRAM address.
- OP_cen  out  1  SRAM chip enable, active low.
- OP_wen  out  1  SRAM write enable, active low; tied to 1 (never writes).
- out_data  out  DATA_BW  head word of the output buffer.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.

Behaviour:
- Reset values (reset=0, asynchronous):
  - busy=0, done=0, out_valid=0, out_data=0.
  - OP_cen=1, OP_wen=1, OP_addr=0.
  - Buffer emptied, counters cleared, state=IDLE.
- State IDLE:
  - start=1 with num_words>0: latch base_addr and num_words; issued=0, accepted=0; go to READ.
  - start=1 with num_words=0: go to FIN with no SRAM access.
- State READ:
  - Issue a read (OP_cen=0, OP_addr=base+issued, mod 2^ADDR_BW) only when buf_count + inflight + 0 < BUF_DEPTH, with buf_count counted after this cycle's pop.
  - inflight is 1 in the cycle after an issue, since read data lands in the buffer one cycle later.
  - Otherwise OP_cen=1.
  - When issued reaches num_words, go to DRAIN.
- State DRAIN:
  - No new reads; OP_cen=1.
  - When accepted==num_words and the buffer is empty, go to FIN.
- State FIN:
  - done=1 for exactly one cycle, busy=0 in that cycle; return to IDLE.
- Buffer:
  - Push occurs on the cycle after an issue, capturing OP_q.
  - Pop occurs on out_valid & out_ready.
  - Simultaneous push and pop is allowed; count is unchanged.
  - Words leave in address order.
  - out_valid = (buf_count != 0).
  - out_data holds steady while out_valid=1 and out_ready=0.
- Throughput and latency:
  - With out_ready held at 1, one word per cycle is sustained after a 2-cycle initial latency (start -> first out_valid).
  - Total cycles from start to done is num_words+3.
- Address wrap: base_addr + num_words beyond 2^ADDR_BW wraps to 0. No error is flagged.
- Reset mid-transfer:
  - All state clears immediately and any in-flight read is discarded.
  - No done pulse is produced.
- start while busy: ignored, with no effect on counters.
- OP_wen is never 0 under any condition.

Optional Feature:
- Macro OP_READ_CHECKSUM_EN.
- When defined:
  - Adds output port checksum [DATA_BW-1:0].
  - It is the running XOR of every word accepted downstream during the current transfer.
  - Cleared to 0 on accepted start and on reset; held stable from the done pulse until the next start.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic stream:
  - Stimulus: preload OP[0..7] = {i,i,...}; start with base=0, num=8, out_ready=1.
  - Response: OP_cen low for 8 consecutive cycles; out_valid first asserts 2 cycles after start; words 0..7 in order; done at cycle 11.
- Back-pressure:
  - Stimulus: base=16, num=6; toggle out_ready 1,0,0,1,0,1...
  - Response: exactly 6 words 16..21 accepted with no duplicate or drop; out_data is stable during stalls; OP_cen=1 whenever the buffer plus in-flight read equals 2.
- Zero length:
  - Stimulus: start with num=0.
  - Response: no OP_cen=0 cycle; done pulses once, 1 cycle after start; out_valid stays 0.
- Wrap:
  - Stimulus: base=510, num=4.
  - Response: OP_addr sequence 510, 511, 0, 1; data order matches.
- Reset mid-operation:
  - Stimulus: drive reset=0 after 3 words of num=10.
  - Response: outputs return to reset values asynchronously; no done pulse.
  - Follow-up: a new start with base=0, num=2 completes normally.
- Checksum (OP_READ_CHECKSUM_EN only):
  - Stimulus: words 0x1, 0x2, 0x4.
  - Response: checksum = 0x7 at done; holds through idle until the next start.
